io_cmd_arbiter: RTL and testbench
=================================

# io_cmd_arbiter

Host-side controller that shares the single toggle-handshake command port of the CPLD I/O register block among several internal requesters. It round-robin arbitrates pending requests and launches one 4-bit command plus 8-bit operand at a time. It waits for the device's sync echo, captures the 8-bit response and returns it to the winning requester. An optional watchdog aborts transactions the device never acknowledges.

## Interface
- NUM_REQ, 4, number of requesters, legal range 2..8
- TIMEOUT_CYCLES, 64, WAIT-state cycles before abort, legal range 2..255; used only with the watchdog compiled in
- i_clk  in  1  clock; the device samples on the falling edge of the same clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NUM_REQ  per-requester request level
- i_req_cmd  in  4*NUM_REQ  command of requester k at bits [4k+3:4k]
- i_req_data  in  8*NUM_REQ  operand of requester k at bits [8k+7:8k]
- o_gnt  out  NUM_REQ  one-hot completion pulse to the served requester
- o_rsp_valid  out  1  one-cycle response strobe
- o_rsp_data  out  8  captured response, held until the next strobe
- o_rsp_id  out  clog2(NUM_REQ)  index of the served requester
- o_rsp_err  out  1  high with o_rsp_valid when the transaction timed out
- o_busy  out  1  high from ISSUE through DONE
- o_timeout  out  1  one-cycle abort pulse
- o_io_sync  out  1  toggle line to the device
- o_io_cmd  out  4  command to the device
- o_io_data  out  8  operand to the device
- i_io_sync  in  1  device echo of sync
- i_io_data  in  8  device response byte

## Operation
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, watchdog counter 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any i_req is set, rr_arbiter picks the first set bit at or after the pointer, wrapping past NUM_REQ-1 to 0. The winner's cmd/data are registered onto o_io_cmd/o_io_data, then the FSM goes to ISSUE.
  - ISSUE: o_io_sync toggles, then the FSM goes to WAIT.
  - WAIT: i_io_sync is registered once into echo_q. When echo_q == o_io_sync, i_io_data is registered into o_rsp_data and the FSM goes to DONE.
  - DONE: o_rsp_valid, o_gnt[id] and o_rsp_id are asserted for one cycle. The pointer moves to id+1 mod NUM_REQ, then the FSM returns to IDLE.
- Requester rules: hold i_req, cmd and data stable until o_gnt. Deassert i_req in the cycle after o_gnt, or it is re-arbitrated. Dropping i_req before selection withdraws the request with no side effect.
- Command encodings are not interpreted. CMD_IDLE (0000) is issued like any other command.
- Simultaneous requests: the pointer decides. A requester never waits more than NUM_REQ-1 transactions.
- New requests arriving during ISSUE, WAIT or DONE are only considered in the next IDLE.

## Timing
- o_io_cmd/o_io_data change only on IDLE->ISSUE. They are stable for at least one full cycle before the o_io_sync edge and remain stable until DONE.
- Minimum latency, i_req high to o_gnt: 4 cycles plus device echo delay plus 1 cycle for the echo_q register.
- o_busy rises on entry to ISSUE and falls on the DONE->IDLE transition.
- Back-to-back transactions: there is one idle cycle between DONE and the next ISSUE.
- Reset asserted mid-transaction immediately forces all reset values, including o_io_sync=0. Software must also reset the device, so that its sync returns to 0 and stays aligned.

## Configuration
- Macro: IO_CMD_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs, cleared on entry to WAIT.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to DONE with o_rsp_err=1, o_rsp_data=8'hFF and o_timeout pulsed.
  - o_io_sync is not reverted. The next transaction toggles again and completes on equality.
- Undefined: WAIT is unbounded, the counter is absent, and o_rsp_err and o_timeout are tied 0.

## Structure
- Shared package io_bus_pkg contains:
  - the command encodings CMD_IDLE 0000, CMD_READ_REG 0001, CMD_RX_BYTE 0100, CMD_TX_BYTE 0101, CMD_RX_TX_BYTE 0110, and CMD_WRITE_REG 1aaa (aaa = register address);
  - the FSM state encoding;
  - the 8'hFF timeout response constant.
- Sub-module rr_arbiter: NUM_REQ-wide combinational pointer-based picker, producing a one-hot output plus an index. The pointer register stays in io_cmd_arbiter.

## Test plan
- Single read:
  - Stimulus: req1, cmd 0001, data 0x03; device echoes 3 cycles after the toggle, with i_io_data=0xA5.
  - Response: o_io_sync 0->1, o_io_cmd=0001, o_io_data=0x03; o_rsp_valid pulses with o_rsp_data=0xA5, o_rsp_id=1, o_gnt=0010.
- Contention: all four requesters set right after reset -> grant order 0,1,2,3. Then req0 and req2 are raised -> order 0 then 2.
- Write: req3, cmd 1011, data 0x5A -> the bus holds 1011/0x5A for at least one cycle before the sync edge. o_rsp_valid returns the device echo byte.
- Timeout (macro on, TIMEOUT_CYCLES=16): device never echoes -> after 16 WAIT cycles, o_timeout, o_rsp_err and o_rsp_valid pulse together with o_rsp_data=0xFF, and o_busy falls.
- Reset in WAIT: i_rst_n low for 1 cycle -> all outputs return to 0. After release and a device reset, a new request toggles o_io_sync 0->1 and completes normally.
- Withdrawal: req2 pulses for 1 cycle while busy serving req0 -> no o_gnt[2] and no extra bus transaction.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared definitions for the CPLD I/O command port: command encodings, the
// arbiter FSM state encoding and the timeout response byte.
package io_bus_pkg;

    localparam logic [3:0] CMD_IDLE       = 4'b0000;
    localparam logic [3:0] CMD_READ_REG   = 4'b0001;
    localparam logic [3:0] CMD_RX_BYTE    = 4'b0100;
    localparam logic [3:0] CMD_TX_BYTE    = 4'b0101;
    localparam logic [3:0] CMD_RX_TX_BYTE = 4'b0110;
    localparam logic [3:0] CMD_WRITE_REG  = 4'b1000;

    // Register writes carry the 3-bit target address in the low command bits.
    function automatic logic [3:0] cmd_write_reg(input logic [2:0] addr);
        return CMD_WRITE_REG | {1'b0, addr};
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] RSP_TIMEOUT = 8'hFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping past NUM_REQ-1 to 0. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);

    localparam int IDW = $clog2(NUM_REQ);

    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        // NOTE: every variable this block writes gets a value before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        o_gnt    = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(i_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDW'(cand);
            if (!o_valid && i_req[cand_idx]) begin
                o_valid         = 1'b1;
                o_idx           = cand_idx;
                o_gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_cmd_arbiter.sv
// Round-robin sharing of the toggle-handshake CPLD command port among NUM_REQ
// requesters. Optional WAIT watchdog is compiled in with IO_CMD_ARB_TIMEOUT_EN.
module io_cmd_arbiter
    import io_bus_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [4*NUM_REQ-1:0]       i_req_cmd,
    input  logic [8*NUM_REQ-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic                       o_rsp_valid,
    output logic [7:0]                 o_rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic                       o_rsp_err,
    output logic                       o_busy,
    output logic                       o_timeout,
    output logic                       o_io_sync,
    output logic [3:0]                 o_io_cmd,
    output logic [7:0]                 o_io_data,
    input  logic                       i_io_sync,
    input  logic [7:0]                 i_io_data
);

    localparam int IDW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [NUM_REQ-1:0]   sel_q, sel_d;
    logic [3:0]           io_cmd_q, io_cmd_d;
    logic [7:0]           io_data_q, io_data_d;
    logic                 io_sync_q, io_sync_d;
    logic                 echo_q;
    logic [7:0]           rsp_data_q, rsp_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic                 busy_q, busy_d;
    logic                 finish;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_valid;

`ifdef IO_CMD_ARB_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q, wdog_d;
    logic       rsp_err_q, rsp_err_d;
    logic       timeout_q, timeout_d;
`else
    logic       unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_gnt   (arb_gnt),
        .o_idx   (arb_idx),
        .o_valid (arb_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        sel_d       = sel_q;
        io_cmd_d    = io_cmd_q;
        io_data_d   = io_data_q;
        io_sync_d   = io_sync_q;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        gnt_d       = '0;
        rsp_id_d    = '0;
        finish      = 1'b0;
`ifdef IO_CMD_ARB_TIMEOUT_EN
        wdog_d      = wdog_q;
        rsp_err_d   = 1'b0;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Requests are only looked at here; anything raised while busy
                // waits for the next IDLE cycle.
                if (arb_valid) begin
                    id_d      = arb_idx;
                    sel_d     = arb_gnt;
                    io_cmd_d  = i_req_cmd[4*arb_idx +: 4];
                    io_data_d = i_req_data[8*arb_idx +: 8];
                    busy_d    = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Command/operand were registered a full cycle before this edge.
                io_sync_d = ~io_sync_q;
                state_d   = ST_WAIT;
`ifdef IO_CMD_ARB_TIMEOUT_EN
                wdog_d    = '0;
`endif
            end
            ST_WAIT: begin
                if (echo_q == io_sync_q) begin
                    rsp_data_d = i_io_data;
                    finish     = 1'b1;
                end
`ifdef IO_CMD_ARB_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    // Sync is left toggled; the next transaction toggles again.
                    rsp_data_d = RSP_TIMEOUT;
                    rsp_err_d  = 1'b1;
                    timeout_d  = 1'b1;
                    finish     = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                ptr_d   = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            gnt_d       = sel_q;
            rsp_id_d    = id_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            sel_q       <= '0;
            io_cmd_q    <= '0;
            io_data_q   <= '0;
            io_sync_q   <= 1'b0;
            echo_q      <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            gnt_q       <= '0;
            rsp_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            sel_q       <= sel_d;
            io_cmd_q    <= io_cmd_d;
            io_data_q   <= io_data_d;
            io_sync_q   <= io_sync_d;
            echo_q      <= i_io_sync;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            gnt_q       <= gnt_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

`ifdef IO_CMD_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q    <= '0;
            rsp_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            rsp_err_q <= rsp_err_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_rsp_err = rsp_err_q;
    assign o_timeout = timeout_q;
`else
    assign o_rsp_err = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_gnt       = gnt_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_busy      = busy_q;
    assign o_io_sync   = io_sync_q;
    assign o_io_cmd    = io_cmd_q;
    assign o_io_data   = io_data_q;

endmodule

// File: tb/tb_io_cmd_arbiter.sv
// Randomized bench for io_cmd_arbiter: a falling-edge device model echoes the
// sync toggle, and a queue-free round-robin reference predicts every grant.
`timescale 1ns/1ps
module tb_io_cmd_arbiter;
    import io_bus_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   i_req = '0;
    logic [4*N-1:0] i_req_cmd = '0;
    logic [8*N-1:0] i_req_data = '0;
    logic [N-1:0]   o_gnt;
    logic           o_rsp_valid;
    logic [7:0]     o_rsp_data;
    logic [1:0]     o_rsp_id;
    logic           o_rsp_err;
    logic           o_busy;
    logic           o_timeout;
    logic           o_io_sync;
    logic [3:0]     o_io_cmd;
    logic [7:0]     o_io_data;
    logic           i_io_sync = 1'b0;
    logic [7:0]     i_io_data = '0;

    always #5 clk = ~clk;

    io_cmd_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (i_req),
        .i_req_cmd   (i_req_cmd),
        .i_req_data  (i_req_data),
        .o_gnt       (o_gnt),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_err   (o_rsp_err),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_io_sync   (o_io_sync),
        .o_io_cmd    (o_io_cmd),
        .o_io_data   (o_io_data),
        .i_io_sync   (i_io_sync),
        .i_io_data   (i_io_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- device model (samples on the falling edge) ----------
    logic       dev_last = 1'b0;
    bit         dev_pending = 1'b0;
    bit         dev_echo_en = 1'b1;
    int         dev_delay = 1;
    int         dev_cnt = 0;
    bit         dev_fixed_en = 1'b0;
    logic [7:0] dev_fixed = '0;
    int         toggles = 0;
    logic [3:0] tog_cmd = '0, setup_cmd = '0, prev_cmd = '0;
    logic [7:0] tog_data = '0, setup_data = '0, prev_data = '0;

    function automatic logic [7:0] dev_rsp_of(input logic [3:0] c, input logic [7:0] d);
        return d ^ {c, ~c};
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_io_sync !== dev_last) begin
            dev_last   = o_io_sync;
            toggles    = toggles + 1;
            tog_cmd    = o_io_cmd;
            tog_data   = o_io_data;
            setup_cmd  = prev_cmd;
            setup_data = prev_data;
            if (dev_echo_en) begin
                dev_pending = 1'b1;
                dev_cnt     = dev_delay;
            end
        end
        if (dev_pending) begin
            if (dev_cnt == 0) begin
                i_io_data   = dev_fixed_en ? dev_fixed : dev_rsp_of(tog_cmd, tog_data);
                i_io_sync   = dev_last;
                dev_pending = 1'b0;
            end else begin
                dev_cnt = dev_cnt - 1;
            end
        end
        prev_cmd  = o_io_cmd;
        prev_data = o_io_data;
    end

    task automatic dev_reset();
        dev_pending = 1'b0;
        dev_last    = 1'b0;
        i_io_sync   = 1'b0;
        i_io_data   = '0;
    endtask

    // ---------------- reference model --------------------------------------
    bit [N-1:0] model_req = '0;
    int         model_ptr = 0;
    int         ntx = 0;
    logic [3:0] req_cmd [N];
    logic [7:0] req_data[N];
    int         order[$];

    function automatic int rr_pick(input bit [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_rsp(input int w);
        return dev_fixed_en ? dev_fixed : dev_rsp_of(req_cmd[w], req_data[w]);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_vec();
        for (int k = 0; k < N; k++) begin
            i_req_cmd[4*k +: 4]  = req_cmd[k];
            i_req_data[8*k +: 8] = req_data[k];
        end
    endtask

    task automatic start_one(input int k, input logic [3:0] c, input logic [7:0] d);
        req_cmd[k]   = c;
        req_data[k]  = d;
        model_req[k] = 1'b1;
        drive_vec();
        i_req[k] = 1'b1;
    endtask

    task automatic start_rand(input bit [N-1:0] set);
        for (int k = 0; k < N; k++) begin
            if (set[k]) start_one(k, 4'($urandom), 8'($urandom));
        end
    endtask

    task automatic serve();
        int w;
        logic [11:0] bus_exp;
        w = rr_pick(model_req, model_ptr);
        if (w < 0) begin
            check("unexpected_rsp", 32'(o_rsp_valid), 32'd0);
            return;
        end
        bus_exp = {req_cmd[w], req_data[w]};
        check("rsp_id",    32'(o_rsp_id), 32'(w));
        check("gnt",       32'(o_gnt), 32'(1 << w));
        check("rsp_data",  32'(o_rsp_data), 32'(exp_rsp(w)));
        check("rsp_err",   32'(o_rsp_err), 32'd0);
        check("timeout",   32'(o_timeout), 32'd0);
        check("bus_edge",  32'({tog_cmd, tog_data}), 32'(bus_exp));
        check("bus_setup", 32'({setup_cmd, setup_data}), 32'(bus_exp));
        check("bus_hold",  32'({o_io_cmd, o_io_data}), 32'(bus_exp));
        check("busy_done", 32'(o_busy), 32'd1);
        check("toggles",   32'(toggles), 32'(ntx + 1));
        check("io_sync",   32'(o_io_sync), 32'((ntx + 1) & 1));
        order.push_back(w);
        model_req[w] = 1'b0;
        i_req[w]     = 1'b0;
        model_ptr    = (w + 1) % N;
        ntx++;
        tick();
        check("busy_idle", 32'(o_busy), 32'd0);
        check("valid_one", 32'(o_rsp_valid), 32'd0);
    endtask

    task automatic wait_all(input int budget);
        int cyc = 0;
        while (model_req != 0) begin
            tick();
            cyc++;
            if (o_rsp_valid) begin
                serve();
            end else if (cyc > budget) begin
                check("wait_bound", 32'(model_req), 32'd0);
                model_req = '0;
                i_req     = '0;
            end
        end
    endtask

    task automatic apply_reset();
        tick();
        rst_n = 1'b0;
        dev_reset();
        i_req = '0;
        #1;
        model_req = '0;
        model_ptr = 0;
        ntx       = 0;
        toggles   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    32'(o_gnt), 32'd0);
        check({tag, "_valid"},  32'(o_rsp_valid), 32'd0);
        check({tag, "_data"},   32'(o_rsp_data), 32'd0);
        check({tag, "_id"},     32'(o_rsp_id), 32'd0);
        check({tag, "_err"},    32'(o_rsp_err), 32'd0);
        check({tag, "_busy"},   32'(o_busy), 32'd0);
        check({tag, "_to"},     32'(o_timeout), 32'd0);
        check({tag, "_sync"},   32'(o_io_sync), 32'd0);
        check({tag, "_iocmd"},  32'(o_io_cmd), 32'd0);
        check({tag, "_iodata"}, 32'(o_io_data), 32'd0);
    endtask

    initial begin
        int k;
        int valids;
        for (int i = 0; i < N; i++) begin
            req_cmd[i]  = '0;
            req_data[i] = '0;
        end

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Contention right after reset: pointer 0 decides
        order.delete();
        dev_delay = 1;
        start_rand(4'hF);
        wait_all(200);
        check("order_all", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("order_all_k", 32'(order[i]), 32'(i));

        order.delete();
        start_rand(4'b0101);
        wait_all(200);
        check("order_02_n", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            check("order_02_a", 32'(order[0]), 32'd0);
            check("order_02_b", 32'(order[1]), 32'd2);
        end

        // Single read with a fixed device byte and a 3-cycle echo
        dev_fixed_en = 1'b1;
        dev_fixed    = 8'hA5;
        dev_delay    = 3;
        start_one(1, CMD_READ_REG, 8'h03);
        wait_all(200);
        dev_fixed_en = 1'b0;

        // Register write to address 3
        start_one(3, cmd_write_reg(3'b011), 8'h5A);
        wait_all(200);

        // Withdrawal: req2 pulses for one cycle while req0 is being served
        start_one(0, CMD_IDLE, 8'h11);
        k = 0;
        while (!o_busy && k < 20) begin
            tick();
            k++;
        end
        check("withdraw_busy", 32'(o_busy), 32'd1);
        i_req[2] = 1'b1;
        tick();
        i_req[2] = 1'b0;
        wait_all(200);
        valids = 0;
        repeat (15) begin
            tick();
            if (o_rsp_valid || o_gnt != 0) valids++;
        end
        check("withdraw_extra_rsp", 32'(valids), 32'd0);
        check("withdraw_toggles", 32'(toggles), 32'(ntx));

        // Reset while waiting for the echo
        dev_delay = 3;
        start_one(3, CMD_RX_BYTE, 8'h77);
        k = 0;
        while (toggles == ntx && k < 20) begin
            tick();
            k++;
        end
        check("rstwait_issued", 32'(toggles), 32'(ntx + 1));
        tick();
        apply_reset();
        check_all_zero("rstwait");
        tick();
        rst_n = 1'b1;
        order.delete();
        start_one(0, CMD_TX_BYTE, 8'h3C);
        start_one(3, CMD_RX_TX_BYTE, 8'hC3);
        wait_all(200);
        if (order.size() > 0) check("rstwait_ptr", 32'(order[0]), 32'd0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            dev_delay = int'($urandom_range(0, 4));
            start_rand(4'($urandom_range(1, 15)));
            wait_all(300);
            if ($urandom_range(0, 1) == 1) tick();
        end

`ifdef IO_CMD_ARB_TIMEOUT_EN
        // Device never echoes: abort after TO wait cycles
        dev_echo_en = 1'b0;
        start_one(0, CMD_READ_REG, 8'h42);
        model_req = '0;
        k = 0;
        while (toggles == ntx && k < 20) begin
            tick();
            k++;
        end
        check("to_issued", 32'(toggles), 32'(ntx + 1));
        k = 0;
        while (!o_rsp_valid && k < 100) begin
            tick();
            k++;
        end
        check("to_cycles", 32'(k), 32'(TO));
        check("to_valid",  32'(o_rsp_valid), 32'd1);
        check("to_err",    32'(o_rsp_err), 32'd1);
        check("to_pulse",  32'(o_timeout), 32'd1);
        check("to_data",   32'(o_rsp_data), 32'hFF);
        check("to_gnt",    32'(o_gnt), 32'd1);
        check("to_busy",   32'(o_busy), 32'd1);
        i_req[0] = 1'b0;
        tick();
        check("to_busy_fall", 32'(o_busy), 32'd0);
        check("to_pulse_end", 32'(o_timeout), 32'd0);
        check("to_err_end",   32'(o_rsp_err), 32'd0);
        apply_reset();
        tick();
        rst_n       = 1'b1;
        dev_echo_en = 1'b1;
        start_one(2, CMD_READ_REG, 8'h24);
        wait_all(200);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
